// File: rtl/cs_sequencer.sv
// cs_sequencer: one-entry decode buffer that indexes a registered
// control-store ROM and presents the microcode word downstream.
module cs_sequencer #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_ir,
  input  logic [PC_W-1:0] in_pc,
  output logic [5:0]      cs_addr,
  input  logic [22:0]     cs_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_ir,
  output logic [PC_W-1:0] out_pc,
  output logic [22:0]     out_cs,
  output logic            out_illegal,
  input  logic            flush,
  output logic [15:0]     inst_count,
  output logic [15:0]     stall_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  logic [5:0] last_addr;
  logic [5:0] in_addr;
  logic [3:0] op;
  logic       accept;
  logic       fire;
  logic       stall;
  logic       ill_op;

  assign out_valid = (state == FULL);

  assign in_ready = rst_n & ~flush
                  & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  assign in_addr = {in_ir[15:12], in_ir[11], in_ir[5]};

  // Hold the last issued address so the ROM word stays put while stalled.
  assign cs_addr = !rst_n ? 6'd0
                 : accept ? in_addr
                 : last_addr;

  assign fire  = out_valid & out_ready & ~flush;
  assign stall = out_valid & ~out_ready & ~flush;

  assign out_cs = (rst_n & out_valid) ? cs_data : 23'd0;

  assign op = out_ir[15:12];

  always_comb begin
    ill_op = 1'b0;
    unique case (1'b1)
      op == 4'h8,
      op == 4'hA,
      op == 4'hB: ill_op = 1'b1;
      default:    ill_op = 1'b0;
    endcase
  end

  assign out_illegal = rst_n & out_valid & ill_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_ir      <= '0;
      out_pc      <= '0;
      last_addr   <= '0;
      inst_count  <= '0;
      stall_count <= '0;
    end else begin
      if (fire)
        inst_count <= inst_count + 16'd1;
      if (stall)
        stall_count <= stall_count + 16'd1;

      unique case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            out_ir    <= in_ir;
            out_pc    <= in_pc;
            last_addr <= in_addr;
          end
        end
        FULL: begin
          if (flush) begin
            state <= EMPTY;
          end else if (accept) begin
            state     <= FULL;
            out_ir    <= in_ir;
            out_pc    <= in_pc;
            last_addr <= in_addr;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_sequencer.sv
// tb_cs_sequencer: directed and randomized checks of cs_sequencer
// against a transaction-level model with a registered ROM.
module tb_cs_sequencer;

  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_ir;
  logic [PC_W-1:0] in_pc;
  logic [5:0]      cs_addr;
  logic [22:0]     cs_data = '0;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_ir;
  logic [PC_W-1:0] out_pc;
  logic [22:0]     out_cs;
  logic            out_illegal;
  logic            flush;
  logic [15:0]     inst_count;
  logic [15:0]     stall_count;

  int vectors = 0;
  int errors  = 0;

  logic [22:0] rom [64];

  bit          m_valid;
  logic [15:0] m_ir;
  logic [15:0] m_pc;
  logic [5:0]  m_last;
  logic [15:0] m_inst;
  logic [15:0] m_stall;

  always #5 clk = ~clk;

  always @(posedge clk) cs_data <= rom[cs_addr];

  cs_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc),
    .cs_addr(cs_addr), .cs_data(cs_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc(out_pc),
    .out_cs(out_cs), .out_illegal(out_illegal),
    .flush(flush),
    .inst_count(inst_count), .stall_count(stall_count)
  );

  function automatic logic [5:0] uaddr(input logic [15:0] ir);
    return {ir[15:12], ir[11], ir[5]};
  endfunction

  function automatic bit is_ill(input logic [15:0] ir);
    logic [3:0] o;
    o = ir[15:12];
    return (o == 4'h8) || (o == 4'hA) || (o == 4'hB);
  endfunction

  function automatic bit e_ready();
    return rst_n && !flush && (!m_valid || out_ready);
  endfunction

  function automatic logic [5:0] e_addr();
    if (!rst_n) return 6'd0;
    if (in_valid && e_ready()) return uaddr(in_ir);
    return m_last;
  endfunction

  function automatic logic [22:0] e_cs();
    return (rst_n && m_valid) ? rom[uaddr(m_ir)] : 23'd0;
  endfunction

  // Advance the model by one clock using the inputs now applied.
  task automatic tick();
    bit acc;
    acc = in_valid && e_ready();
    if (!rst_n) begin
      m_valid = 0; m_ir = '0; m_pc = '0;
      m_last = '0; m_inst = '0; m_stall = '0;
    end else begin
      if (m_valid && !flush) begin
        if (out_ready) m_inst = m_inst + 16'd1;
        else m_stall = m_stall + 16'd1;
      end
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_ir = in_ir; m_pc = in_pc;
        m_last = uaddr(in_ir);
      end else if (out_ready) m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_ir = '0; in_pc = '0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; in_valid = 1;
    in_ir = 16'h1021; in_pc = 16'h3000; out_ready = 1;
    tick(); tick();
    #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    vectors++; if (inst_count !== 16'd0) begin errors++; $display("FAIL rst_inst got=%0h exp=0", inst_count); end
    vectors++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", stall_count); end
    vectors++; if (cs_addr !== 6'd0) begin errors++; $display("FAIL rst_cs_addr got=%0h exp=0", cs_addr); end
    vectors++; if (out_cs !== 23'd0 || out_illegal !== 1'b0) begin errors++; $display("FAIL rst_out_cs got=%0h/%0h exp=0/0", out_cs, out_illegal); end
    vectors++; if (out_ir !== 16'd0 || out_pc !== 16'd0) begin errors++; $display("FAIL rst_out_ir got=%0h/%0h exp=0/0", out_ir, out_pc); end
    rst_n = 1; in_valid = 0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%0h exp=1", in_ready); end
    tick();
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_no_accept got=%0h exp=0", out_valid); end
  endtask

  task automatic test_single_add();
    do_reset();
    in_valid = 1; in_ir = 16'h1021; in_pc = 16'h3000; out_ready = 1;
    #1;
    vectors++; if (cs_addr !== 6'd5) begin errors++; $display("FAIL add_cs_addr got=%0d exp=5", cs_addr); end
    tick();
    in_valid = 0;
    #1;
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0h exp=1", out_valid); end
    vectors++; if (out_pc !== 16'h3000) begin errors++; $display("FAIL add_pc got=%0h exp=3000", out_pc); end
    vectors++; if (out_cs !== 23'h40480F) begin errors++; $display("FAIL add_cs got=%0h exp=40480f", out_cs); end
    vectors++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal got=%0h exp=0", out_illegal); end
    tick();
    #1;
    vectors++; if (inst_count !== 16'd1) begin errors++; $display("FAIL add_inst got=%0d exp=1", inst_count); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1; in_ir = 16'h1021; in_pc = 16'h3000; out_ready = 1;
    #1;
    vectors++; if (cs_addr !== 6'd5) begin errors++; $display("FAIL b2b_addr0 got=%0d exp=5", cs_addr); end
    tick();
    in_ir = 16'h6283; in_pc = 16'h3001;
    #1;
    vectors++; if (cs_addr !== 6'd24) begin errors++; $display("FAIL b2b_addr1 got=%0d exp=24", cs_addr); end
    vectors++; if (out_valid !== 1'b1 || out_cs !== 23'h40480F) begin errors++; $display("FAIL b2b_first got=%0h/%0h exp=1/40480f", out_valid, out_cs); end
    tick();
    in_valid = 0;
    #1;
    vectors++; if (out_valid !== 1'b1 || out_cs !== 23'h4B8057) begin errors++; $display("FAIL b2b_second got=%0h/%0h exp=1/4b8057", out_valid, out_cs); end
    vectors++; if (out_ir !== 16'h6283 || out_pc !== 16'h3001) begin errors++; $display("FAIL b2b_ir got=%0h/%0h exp=6283/3001", out_ir, out_pc); end
    tick();
    #1;
    vectors++; if (inst_count !== 16'd2) begin errors++; $display("FAIL b2b_inst got=%0d exp=2", inst_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1; in_ir = 16'h1021; in_pc = 16'h3000; out_ready = 1;
    tick();
    in_ir = 16'h6283; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", i, in_ready); end
      vectors++; if (out_ir !== 16'h1021 || out_cs !== 23'h40480F) begin errors++; $display("FAIL bp_hold[%0d] got=%0h/%0h exp=1021/40480f", i, out_ir, out_cs); end
      vectors++; if (cs_addr !== 6'd5) begin errors++; $display("FAIL bp_addr[%0d] got=%0d exp=5", i, cs_addr); end
      tick();
    end
    #1;
    vectors++; if (stall_count !== 16'd3) begin errors++; $display("FAIL bp_stall got=%0d exp=3", stall_count); end
    out_ready = 1; in_valid = 0;
    tick();
    #1;
    vectors++; if (inst_count !== 16'd1 || stall_count !== 16'd3) begin errors++; $display("FAIL bp_release got=%0d/%0d exp=1/3", inst_count, stall_count); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0h exp=0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1; in_ir = 16'h1021; in_pc = 16'h3000; out_ready = 1;
    tick();
    in_ir = 16'h6283; flush = 1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready got=%0h exp=0", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_cs !== 23'd0) begin errors++; $display("FAIL fl_empty got=%0h/%0h exp=0/0", out_valid, out_cs); end
    vectors++; if (inst_count !== 16'd0) begin errors++; $display("FAIL fl_inst got=%0d exp=0", inst_count); end
    vectors++; if (out_ir !== 16'h1021) begin errors++; $display("FAIL fl_not_taken got=%0h exp=1021", out_ir); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_ir     = 16'($urandom);
      in_pc     = 16'($urandom);
      #1;
      vectors++; if (in_ready !== e_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d] got=%0h exp=%0h", i, in_ready, e_ready()); end
      vectors++; if (cs_addr !== e_addr()) begin errors++; $display("FAIL rnd_cs_addr[%0d] got=%0d exp=%0d", i, cs_addr, e_addr()); end
      vectors++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got=%0h exp=%0h", i, out_valid, m_valid); end
      vectors++; if (out_ir !== m_ir || out_pc !== m_pc) begin errors++; $display("FAIL rnd_ir[%0d] got=%0h/%0h exp=%0h/%0h", i, out_ir, out_pc, m_ir, m_pc); end
      vectors++; if (out_cs !== e_cs()) begin errors++; $display("FAIL rnd_cs[%0d] got=%0h exp=%0h", i, out_cs, e_cs()); end
      vectors++; if (out_illegal !== (rst_n && m_valid && is_ill(m_ir))) begin errors++; $display("FAIL rnd_illegal[%0d] got=%0h", i, out_illegal); end
      vectors++; if (inst_count !== m_inst || stall_count !== m_stall) begin errors++; $display("FAIL rnd_counts[%0d] got=%0d/%0d exp=%0d/%0d", i, inst_count, stall_count, m_inst, m_stall); end
      tick();
    end
  endtask

  task automatic test_illegal_wrap();
    int n;
    do_reset();
    in_valid = 1; in_ir = 16'h1021; in_pc = 16'h0; out_ready = 1;
    n = 0;
    while (m_inst != 16'hFFFE && n < 70000) begin
      tick();
      n++;
    end
    #1;
    vectors++; if (inst_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_fill got=%0h exp=fffe", inst_count); end
    in_ir = 16'hA000; in_pc = 16'h4000;
    #1;
    vectors++; if (cs_addr !== 6'd40) begin errors++; $display("FAIL ill_addr got=%0d exp=40", cs_addr); end
    tick();
    in_valid = 0;
    #1;
    vectors++; if (out_illegal !== 1'b1 || out_cs !== 23'd0) begin errors++; $display("FAIL ill_out got=%0h/%0h exp=1/0", out_illegal, out_cs); end
    vectors++; if (inst_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got=%0h exp=ffff", inst_count); end
    tick();
    #1;
    vectors++; if (inst_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%0h exp=0", inst_count); end
    vectors++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL ill_clear got=%0h exp=0", out_illegal); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      if (i[5:2] == 4'h8 || i[5:2] == 4'hA || i[5:2] == 4'hB)
        rom[i] = 23'd0;
      else
        rom[i] = 23'((i * 32'h1F3B7) ^ 32'h2A5A5) | 23'h1;
    end
    rom[5]  = 23'h40480F;
    rom[24] = 23'h4B8057;
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_ir = '0; in_pc = '0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_illegal_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
